// File: rtl/gem_frame_tx.sv
// gem_frame_tx
//   Serialises one bunch crossing (BX) of trigger payload per link onto the MGT TX
//   data path. Each BX is FRAMES_PER_BX 16-bit words. Frame 0 carries the low payload
//   byte plus a K-character separator. Frames 1..FRAMES_PER_BX-1 carry the rest of
//   the payload. Links send the idle word FFBC/K while the transmitter is idle or
//   synchronising, and also when the link is masked or the mode is all-idle.
//
//   The per-link word stream is {payload, sep} cut into 16-bit words, LSB first.
//   So frame j >= 1 carries payload[16j+7 -: 16], and the last frame ends at the
//   top payload bit.
//
// Ports
//   clock_160      MGT user clock, one frame per cycle
//   reset_i        synchronous active-high reset
//   ready_i        MGT TX reset-done (synchronous)
//   data_i         payload, link n = data_i[n*DATA_BITS +: DATA_BITS]
//   valid_i        data_i and flags valid at the capture edge
//   overflow_i     more than 8 clusters in this BX
//   bc0_i          BX0 flag
//   resync_i       resync flag
//   bxn_lsbs_i     BX counter LSBs, used for separator rotation
//   link_mask_i    1 = link forced idle
//   mode_i         0 normal, 1 counter pattern, 2/3 all idle
//   tx_data_o      per-link TX data, 16 bits per link
//   tx_isk_o       per-link char-is-K, 2 bits per link
//   bx_strobe_o    high for the cycle ending in each capture edge in RUN
//   running_o      high while in RUN
module gem_frame_tx #(
  parameter int unsigned NUM_LINKS      = 4,
  parameter int unsigned FRAMES_PER_BX  = 4,
  parameter int unsigned FRAME_CTRL_TTC = 1,
  parameter int unsigned SYNC_BX        = 4,
  localparam int unsigned DATA_BITS     = 16 * FRAMES_PER_BX - 8
) (
  input  logic                           clock_160,
  input  logic                           reset_i,
  input  logic                           ready_i,
  input  logic [NUM_LINKS*DATA_BITS-1:0] data_i,
  input  logic                           valid_i,
  input  logic                           overflow_i,
  input  logic                           bc0_i,
  input  logic                           resync_i,
  input  logic [1:0]                     bxn_lsbs_i,
  input  logic [NUM_LINKS-1:0]           link_mask_i,
  input  logic [1:0]                     mode_i,
  output logic [NUM_LINKS*16-1:0]        tx_data_o,
  output logic [NUM_LINKS*2-1:0]         tx_isk_o,
  output logic                           bx_strobe_o,
  output logic                           running_o
);

  localparam int unsigned FcW      = (FRAMES_PER_BX > 1) ? $clog2(FRAMES_PER_BX) : 1;
  localparam int unsigned NumBytes = DATA_BITS / 8;
  localparam logic [15:0] IdleWord = 16'hFFBC;
  localparam logic [1:0]  IdleIsk  = 2'b01;

  typedef enum logic [1:0] {StIdle, StSync, StRun} state_e;

  state_e         state_q, state_d;
  logic [FcW-1:0] frame_q, frame_d;
  logic [7:0]     sync_q, sync_d;   // completed BXs in SYNC
  logic [1:0]     bx_q, bx_d;       // local BX counter for rotation
  logic [7:0]     cnt_q, cnt_d;     // test-pattern counter
  logic           frame_last;
  logic           capture;

  // Capture register: one BX worth of payload, flags and controls
  logic [NUM_LINKS*DATA_BITS-1:0] data_q;
  logic                           bc0_q, resync_q, ovf_q;
  logic [1:0]                     lsbs_q, mode_q;
  logic [NUM_LINKS-1:0]           mask_q;

  logic [NUM_LINKS*16-1:0] tx_data_q, tx_data_d;
  logic [NUM_LINKS*2-1:0]  tx_isk_q, tx_isk_d;

  logic [1:0]                  rot;
  logic [7:0]                  sep;
  logic [DATA_BITS-1:0]        payload;
  logic [16*FRAMES_PER_BX-1:0] stream;
  logic                        send;

  assign frame_last = (frame_q == FcW'(FRAMES_PER_BX - 1));
  assign capture    = frame_last && (state_q != StIdle);

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ready_i) state_d = StSync;
      StSync:  if (frame_last && (sync_q == 8'(SYNC_BX - 1))) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase
    if (!ready_i) state_d = StIdle;
  end

  // Counters
  always_comb begin
    frame_d = '0;
    // Stay at 0 on the IDLE->SYNC edge so SYNC, and hence RUN, starts at frame 0
    if ((state_q != StIdle) && (state_d != StIdle)) begin
      frame_d = frame_last ? '0 : frame_q + 1'b1;
    end

    sync_d = '0;
    if (state_q == StSync) sync_d = frame_last ? sync_q + 8'd1 : sync_q;

    // Zero outside RUN, so it is 0 for the first RUN BX
    bx_d = '0;
    if (state_q == StRun) bx_d = frame_last ? bx_q + 2'd1 : bx_q;

    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if ((state_q == StRun) && frame_last) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Separator selection
  assign rot = (FRAME_CTRL_TTC != 0) ? lsbs_q : bx_q;

  always_comb begin
    sep = 8'hBC;
    if (bc0_q) begin
      sep = 8'h1C;
    end else if (resync_q) begin
      sep = 8'h3C;
    end else if (ovf_q) begin
      sep = 8'hFC;
    end else begin
      case (rot)
        2'd0:    sep = 8'hBC;
        2'd1:    sep = 8'hF7;
        2'd2:    sep = 8'hFB;
        default: sep = 8'hFD;
      endcase
    end
  end

  // Output word selection; ready_i low gives idle on the very next edge
  assign send = (state_q == StRun) && ready_i && !mode_q[1];

  always_comb begin
    tx_data_d = {NUM_LINKS{IdleWord}};
    tx_isk_d  = {NUM_LINKS{IdleIsk}};
    payload   = '0;
    stream    = '0;
    for (int n = 0; n < NUM_LINKS; n++) begin
      if (mode_q == 2'd1) begin
        for (int i = 0; i < NumBytes; i++) payload[8*i +: 8] = cnt_q + 8'(i);
      end else begin
        payload = data_q[n*DATA_BITS +: DATA_BITS];
      end
      stream = {payload, sep};
      if (send && !mask_q[n]) begin
        tx_data_d[16*n +: 16] = stream[16*int'(frame_q) +: 16];
        tx_isk_d[2*n +: 2]    = (frame_q == '0) ? 2'b01 : 2'b00;
      end
    end
  end

  always_ff @(posedge clock_160) begin
    if (reset_i) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      sync_q    <= '0;
      bx_q      <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      bc0_q     <= 1'b0;
      resync_q  <= 1'b0;
      ovf_q     <= 1'b0;
      lsbs_q    <= '0;
      mode_q    <= '0;
      mask_q    <= '0;
      tx_data_q <= {NUM_LINKS{IdleWord}};
      tx_isk_q  <= {NUM_LINKS{IdleIsk}};
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      sync_q    <= sync_d;
      bx_q      <= bx_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_isk_q  <= tx_isk_d;
      if (capture) begin
        data_q   <= valid_i ? data_i : '0;
        bc0_q    <= valid_i & bc0_i;
        resync_q <= valid_i & resync_i;
        ovf_q    <= valid_i & overflow_i;
        lsbs_q   <= bxn_lsbs_i;
        mode_q   <= mode_i;
        mask_q   <= link_mask_i;
      end
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_isk_o    = tx_isk_q;
  assign bx_strobe_o = (state_q == StRun) && frame_last;
  assign running_o   = (state_q == StRun);

endmodule

// File: tb/tb_gem_frame_tx.sv
module tb_gem_frame_tx;

  localparam int MaxBx = 300;
  localparam logic [17:0] IdleExp = {2'b01, 16'hFFBC};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, ready_a, ready_b, valid, ovf, bc0, resync;
  logic [1:0]   lsbs, mode;
  logic [3:0]   mask;
  logic [223:0] data;

  logic [63:0] tx_data_a;
  logic [7:0]  tx_isk_a;
  logic        strobe_a, running_a;
  logic [15:0] tx_data_b;
  logic [1:0]  tx_isk_b;
  logic        strobe_b, running_b;

  gem_frame_tx #(
    .NUM_LINKS(4), .FRAMES_PER_BX(4), .FRAME_CTRL_TTC(1), .SYNC_BX(4)
  ) dut_a (
    .clock_160(clk), .reset_i(rst), .ready_i(ready_a), .data_i(data),
    .valid_i(valid), .overflow_i(ovf), .bc0_i(bc0), .resync_i(resync),
    .bxn_lsbs_i(lsbs), .link_mask_i(mask), .mode_i(mode),
    .tx_data_o(tx_data_a), .tx_isk_o(tx_isk_a), .bx_strobe_o(strobe_a),
    .running_o(running_a)
  );

  gem_frame_tx #(
    .NUM_LINKS(1), .FRAMES_PER_BX(2), .FRAME_CTRL_TTC(0), .SYNC_BX(3)
  ) dut_b (
    .clock_160(clk), .reset_i(rst), .ready_i(ready_b), .data_i(data[23:0]),
    .valid_i(valid), .overflow_i(ovf), .bc0_i(bc0), .resync_i(resync),
    .bxn_lsbs_i(lsbs), .link_mask_i(mask[0:0]), .mode_i(mode),
    .tx_data_o(tx_data_b), .tx_isk_o(tx_isk_b), .bx_strobe_o(strobe_b),
    .running_o(running_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Geometry of the instance currently under test
  bit sel;
  int fp, nl, sb, ttc, db;

  // Per-BX stimulus record used by the reference model
  logic [55:0] st_data   [MaxBx][8];
  bit          st_valid  [MaxBx];
  bit          st_bc0    [MaxBx];
  bit          st_resync [MaxBx];
  bit          st_ovf    [MaxBx];
  logic [1:0]  st_lsbs   [MaxBx];
  logic [1:0]  st_mode   [MaxBx];
  logic [3:0]  st_mask   [MaxBx];
  logic [17:0] obs       [MaxBx][4];  // observed {isk,data} of link 0

  task automatic select_inst(input bit s);
    sel = s;
    if (!s) begin
      fp = 4; nl = 4; sb = 4; ttc = 1;
    end else begin
      fp = 2; nl = 1; sb = 3; ttc = 0;
    end
    db = 16 * fp - 8;
  endtask

  task automatic set_ready(input logic v);
    if (sel) ready_b = v;
    else     ready_a = v;
  endtask

  function automatic logic [17:0] get_out(input int n);
    if (sel) return {tx_isk_b, tx_data_b};
    return {tx_isk_a[2*n +: 2], tx_data_a[16*n +: 16]};
  endfunction

  function automatic logic get_running();
    return sel ? running_b : running_a;
  endfunction

  function automatic logic get_strobe();
    return sel ? strobe_b : strobe_a;
  endfunction

  // Expected {isk, data} for link n, frame j of RUN BX b (b counted from RUN entry)
  function automatic logic [17:0] model(input int b, input int n, input int j);
    logic [55:0] pl;
    logic [7:0]  sp;
    logic [63:0] s;
    int          rot;
    if (st_mode[b] >= 2'd2 || st_mask[b][n]) return IdleExp;
    pl = '0;
    if (st_mode[b] == 2'd1) begin
      for (int i = 0; i < 2 * fp - 1; i++) pl[8*i +: 8] = 8'((b + i) % 256);
    end else if (st_valid[b]) begin
      pl = st_data[b][n];
    end
    rot = (ttc != 0) ? int'(st_lsbs[b]) : (b % 4);
    if (st_valid[b] && st_bc0[b])         sp = 8'h1C;
    else if (st_valid[b] && st_resync[b]) sp = 8'h3C;
    else if (st_valid[b] && st_ovf[b])    sp = 8'hFC;
    else if (rot == 0)                    sp = 8'hBC;
    else if (rot == 1)                    sp = 8'hF7;
    else if (rot == 2)                    sp = 8'hFB;
    else                                  sp = 8'hFD;
    s = {pl, sp};
    return {(j == 0) ? 2'b01 : 2'b00, s[16*j +: 16]};
  endfunction

  // kind: 0 random, 1 directed table, 2 counter mode, 3 plain payload no flags
  task automatic drive_bx(input int kind, input int b);
    logic [55:0] m;
    int          r;
    m = (56'(1) << db) - 56'(1);
    st_valid[b] = 1'b1; st_bc0[b] = 1'b0; st_resync[b] = 1'b0; st_ovf[b] = 1'b0;
    st_lsbs[b] = 2'($urandom); st_mode[b] = 2'd0; st_mask[b] = 4'd0;
    for (int n = 0; n < 8; n++) st_data[b][n] = 56'({$urandom, $urandom}) & m;
    case (kind)
      0: begin
        st_valid[b]  = ($urandom % 8) != 0;
        st_bc0[b]    = ($urandom % 6) == 0;
        st_resync[b] = ($urandom % 6) == 0;
        st_ovf[b]    = ($urandom % 4) == 0;
        r = $urandom % 8;
        st_mode[b] = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r == 6) ? 2'd2 : 2'd3;
        st_mask[b] = (($urandom % 3) == 0) ? 4'($urandom) : 4'd0;
      end
      1: begin
        st_data[b][0] = 56'h0123456789ABCD & m;
        st_lsbs[b] = 2'd1;
        case (b)
          1: begin st_bc0[b] = 1'b1; st_resync[b] = 1'b1; st_ovf[b] = 1'b1; end
          2: begin st_resync[b] = 1'b1; st_ovf[b] = 1'b1; end
          3: st_lsbs[b] = 2'd2;
          4: begin
            st_valid[b] = 1'b0; st_bc0[b] = 1'b1; st_resync[b] = 1'b1;
            st_ovf[b] = 1'b1; st_lsbs[b] = 2'd3;
          end
          default: ;
        endcase
      end
      2: begin
        st_mode[b]  = 2'd1;
        st_mask[b]  = 4'b0010;
        st_valid[b] = ($urandom % 4) != 0;
        st_ovf[b]   = ($urandom % 5) == 0;
      end
      default: ;
    endcase
    valid = st_valid[b]; bc0 = st_bc0[b]; resync = st_resync[b]; ovf = st_ovf[b];
    lsbs = st_lsbs[b]; mode = st_mode[b]; mask = st_mask[b];
    for (int n = 0; n < 4; n++) data[56*n +: 56] = st_data[b][n];
  endtask

  // Raise ready (and drop reset) at a negedge, then stream nbx RUN BXs and check every
  // edge. abort_kind 1 drops ready_i, 2 asserts reset_i, before edge number abort_c.
  task automatic run_stream(input int kind, input int nbx, input int abort_c,
                            input int abort_kind);
    int       ns, k, b, j;
    logic [17:0] exp, got;
    logic     exp_run, exp_stb;
    ns = sb * fp;
    rst = 1'b0;
    set_ready(1'b1);
    for (int c = 0; c <= ns + nbx * fp; c++) begin
      if (c == abort_c) begin
        if (abort_kind == 1) set_ready(1'b0);
        else                 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int n = 0; n < nl; n++) begin
          got = get_out(n);
          n_checks++;
          if (got !== IdleExp) begin
            n_errors++;
            $display("FAIL abort_idle inst%0d kind%0d link%0d got %h exp %h",
                     sel, abort_kind, n, got, IdleExp);
          end
        end
        n_checks++;
        if (get_running() !== 1'b0 || get_strobe() !== 1'b0) begin
          n_errors++;
          $display("FAIL abort_status inst%0d got running=%b strobe=%b exp 0 0",
                   sel, get_running(), get_strobe());
        end
        rst = 1'b0;
        set_ready(1'b0);
        @(posedge clk); @(negedge clk);
        return;
      end
      if (c >= ns && ((c - ns) % fp) == 0 && ((c - ns) / fp) < nbx) drive_bx(kind, (c - ns) / fp);
      @(posedge clk); @(negedge clk);
      exp_run = (c >= ns);
      exp_stb = exp_run && ((c % fp) == fp - 1);
      n_checks++;
      if (get_running() !== exp_run || get_strobe() !== exp_stb) begin
        n_errors++;
        $display("FAIL status inst%0d c=%0d got running=%b strobe=%b exp %b %b",
                 sel, c, get_running(), get_strobe(), exp_run, exp_stb);
      end
      for (int n = 0; n < nl; n++) begin
        if (c <= ns) begin
          exp = IdleExp;
        end else begin
          k = c - ns - 1; b = k / fp; j = k % fp;
          exp = model(b, n, j);
        end
        got = get_out(n);
        if (c > ns && n == 0) obs[(c - ns - 1) / fp][(c - ns - 1) % fp] = got;
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL word inst%0d c=%0d link%0d got %h exp %h", sel, c, n, got, exp);
        end
      end
    end
    set_ready(1'b0);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    select_inst(1'b0);
    rst = 1'b1; ready_a = 1'b1; valid = 1'b1; mode = 2'd1; bc0 = 1'b1;
    data = {7{$urandom}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if ({tx_isk_a[2*n +: 2], tx_data_a[16*n +: 16]} !== IdleExp) begin
        n_errors++;
        $display("FAIL reset_word link%0d got %h exp %h", n,
                 {tx_isk_a[2*n +: 2], tx_data_a[16*n +: 16]}, IdleExp);
      end
    end
    n_checks++;
    if (running_a !== 1'b0 || strobe_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_status got running=%b strobe=%b exp 0 0", running_a, strobe_a);
    end
  endtask

  // Starts straight out of reset with ready_i high
  task automatic test_directed();
    logic [17:0] want [8];
    select_inst(1'b0);
    run_stream(1, 5, -1, 0);
    want[0] = {2'b01, 16'hCDF7}; want[1] = {2'b00, 16'h89AB};
    want[2] = {2'b00, 16'h4567}; want[3] = {2'b00, 16'h0123};
    want[4] = {2'b01, 16'hCD1C}; want[5] = {2'b01, 16'hCD3C};
    want[6] = {2'b01, 16'h00FD}; want[7] = {2'b00, 16'h0000};
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (obs[0][j] !== want[j]) begin
        n_errors++;
        $display("FAIL directed_frame%0d got %h exp %h", j, obs[0][j], want[j]);
      end
    end
    n_checks++;
    if (obs[1][0] !== want[4]) begin
      n_errors++; $display("FAIL directed_bc0 got %h exp %h", obs[1][0], want[4]);
    end
    n_checks++;
    if (obs[2][0] !== want[5]) begin
      n_errors++; $display("FAIL directed_resync got %h exp %h", obs[2][0], want[5]);
    end
    n_checks++;
    if (obs[4][0] !== want[6] || obs[4][1] !== want[7]) begin
      n_errors++;
      $display("FAIL directed_novalid got %h %h exp %h %h", obs[4][0], obs[4][1],
               want[6], want[7]);
    end
  endtask

  task automatic test_random();
    select_inst(1'b0);
    run_stream(0, 40, -1, 0);
  endtask

  task automatic test_ready_drop();
    select_inst(1'b0);
    // Edge ending the frame-2 cycle of the second RUN BX
    run_stream(0, 4, sb * fp + fp + 3, 1);
    run_stream(0, 3, -1, 0);
  endtask

  task automatic test_reset_mid();
    select_inst(1'b0);
    run_stream(0, 4, sb * fp + 2 * fp + 2, 2);
    run_stream(0, 2, -1, 0);
  endtask

  task automatic test_counter();
    select_inst(1'b0);
    run_stream(2, 260, -1, 0);
    n_checks++;
    if (obs[255][0][15:8] !== 8'hFF || obs[255][1] !== {2'b00, 16'h0100}) begin
      n_errors++;
      $display("FAIL counter_ff got %h %h exp byte0 FF frame1 00100", obs[255][0], obs[255][1]);
    end
    n_checks++;
    if (obs[256][0][15:8] !== 8'h00 || obs[256][1] !== {2'b00, 16'h0201}) begin
      n_errors++;
      $display("FAIL counter_wrap got %h %h exp byte0 00 frame1 00201", obs[256][0], obs[256][1]);
    end
  endtask

  task automatic test_small_local_rotation();
    logic [7:0] seps [6];
    seps[0] = 8'hBC; seps[1] = 8'hF7; seps[2] = 8'hFB;
    seps[3] = 8'hFD; seps[4] = 8'hBC; seps[5] = 8'hF7;
    select_inst(1'b1);
    run_stream(3, 6, -1, 0);
    for (int b = 0; b < 6; b++) begin
      n_checks++;
      if (obs[b][0][7:0] !== seps[b]) begin
        n_errors++;
        $display("FAIL local_sep bx%0d got %h exp %h", b, obs[b][0][7:0], seps[b]);
      end
    end
    run_stream(0, 30, -1, 0);
    run_stream(2, 10, -1, 0);
    run_stream(0, 3, sb * fp + 3, 1);
  endtask

  initial begin
    rst = 1'b1; ready_a = 1'b0; ready_b = 1'b0; valid = 1'b0; ovf = 1'b0;
    bc0 = 1'b0; resync = 1'b0; lsbs = 2'd0; mode = 2'd0; mask = 4'd0; data = '0;
    select_inst(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_ready_drop();
    test_reset_mid();
    test_counter();
    test_small_local_rotation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
